gerador_freq: RTL and testbench
===============================

Name: gerador_freq

Overview:
- Programmable square-wave generator (DDS phase accumulator), clocked by the 100 kHz system clock.
- Takes a 4-digit BCD frequency setpoint in Hz (0–9999) and produces the output waveform plus a 1-cycle strobe per output period.
- Acts as the stimulus source for the frequency meter: its output drives the meter's clk_desc input, with BCD digits in the same thousands/hundreds/tens/units layout as the meter's counter.

Parameters:
- F_CLK, 100000, system clock frequency in Hz; also the accumulator modulus.
- ACC_W, 17, accumulator width; requires 2^ACC_W > F_CLK.

Ports:
- clk_sistema_100k  input  1  system clock, rising edge.
- reset_sistema  input  1  asynchronous, active-high reset.
- carga  input  1  load strobe; sampled only in IDLE.
- hab  input  1  output enable.
- bcd_3  input  4  setpoint thousands digit.
- bcd_2  input  4  setpoint hundreds digit.
- bcd_1  input  4  setpoint tens digit.
- bcd_0  input  4  setpoint units digit.
- clk_gerado  output  1  generated square wave, registered.
- pulso  output  1  one-cycle strobe per generated period, registered.
- ocupado  output  1  conversion in progress; carga is ignored while high.
- erro  output  1  last load attempt contained a non-BCD digit.

Behaviour:
- Reset (asynchronous, any state, including mid-conversion):
  - FSM=IDLE; acc=0; inc=0; bin=0; digit shadow regs=0.
  - clk_gerado=0, pulso=0, ocupado=0, erro=0.
  - A conversion in progress is discarded.
- FSM states: IDLE, CONV (4 cycles, idx 3 down to 0), APPLY.
- IDLE, carga=1 at edge k:
  - Capture bcd_3..bcd_0 into shadow registers.
  - If any digit > 9: erro<=1, stay in IDLE, inc unchanged, ocupado stays 0.
  - Otherwise: erro<=0, ocupado<=1, bin<=0, idx<=3, go to CONV.
- CONV (edges k+1..k+4):
  - bin <= bin*10 + shadow[idx]; bin is 14 bits.
  - Thousands digit is consumed first.
  - After idx=0, go to APPLY.
- APPLY (edge k+5):
  - inc<=bin, acc<=0, clk_gerado<=0, pulso<=0, ocupado<=0, go to IDLE.
  - Accumulation with the new inc starts at edge k+6.
- carga while ocupado=1 is ignored, not queued. carga held high re-triggers a load on each return to IDLE.
- Accumulator: every edge not in APPLY with hab=1:
  - sum = acc + inc, 18-bit compare.
  - If sum >= F_CLK: acc <= sum - F_CLK, pulso<=1.
  - Otherwise: acc <= sum, pulso<=0.
  - clk_gerado <= (next acc >= F_CLK/2).
- Accumulator keeps running during IDLE and CONV with the old inc, so the output stays glitch-free until APPLY.
- hab=0: acc<=0, clk_gerado<=0, pulso<=0 on each edge.
  - The FSM and loads still operate.
  - When hab rises, phase restarts from 0.
- inc=0: clk_gerado stays 0, pulso never asserts.
- Average output frequency equals inc Hz exactly. Period jitter is at most 1 clock when F_CLK mod inc ≠ 0.
- Duty cycle: exactly 50% when F_CLK/inc is even; otherwise within ±1 clock.

Test Plan:
- Reset, hab=1, load 1-0-0-0 -> ocupado high for exactly 5 cycles. After that, pulso every 100 cycles, clk_gerado high 50 / low 50. Exactly 1000 pulsos in 100000 cycles.
- Load 0-0-0-3 -> pulso spacings of 33333 or 33334 cycles; exactly 3 pulsos per 100000 cycles.
- Load 9-9-9-9, then load 1-2-A-4 -> second load sets erro=1 with ocupado never asserting. Output continues at 9999 pulsos/100000 cycles. A following valid load 0-5-0-0 clears erro and gives a 200-cycle period.
- Load 0-0-1-0, then pulse carga with 0-0-2-0 while ocupado=1 -> second request ignored; period stays 10000 cycles.
- Assert reset_sistema during CONV cycle 2 -> all outputs 0 immediately, without waiting for a clock edge. After release, no output until a new load.
- Running at 1000 Hz, drop hab for 37 cycles then raise it -> clk_gerado and pulso are 0 while hab=0. First pulso arrives 100 cycles after hab rises.

Source files
------------

// File: rtl/gerador_freq.sv
// Programmable square-wave generator: a 4-digit BCD setpoint is converted to a
// binary phase increment that drives a modulo-F_CLK DDS accumulator.
module gerador_freq #(
  parameter int F_CLK = 100000,
  parameter int ACC_W = 17
) (
  input  logic       clk_sistema_100k,
  input  logic       reset_sistema,
  input  logic       carga,
  input  logic       hab,
  input  logic [3:0] bcd_3,
  input  logic [3:0] bcd_2,
  input  logic [3:0] bcd_1,
  input  logic [3:0] bcd_0,
  output logic       clk_gerado,
  output logic       pulso,
  output logic       ocupado,
  output logic       erro
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, APPLY = 2'd2} estado_t;

  localparam logic [ACC_W:0] MOD_VAL  = (ACC_W + 1)'(F_CLK);
  localparam logic [ACC_W:0] HALF_VAL = (ACC_W + 1)'(F_CLK / 2);

  estado_t          estado_r, estado_next_s;
  logic [1:0]       idx_r, idx_next_s;
  logic [13:0]      bin_r, bin_next_s;
  logic [13:0]      inc_r, inc_next_s;
  logic [ACC_W-1:0] acc_r, acc_next_s;
  logic [3:0]       shadow_r [4];
  logic [3:0]       shadow_next_s [4];
  logic             clk_gerado_next_s, pulso_next_s, ocupado_next_s, erro_next_s;
  logic             digito_invalido_s;
  logic [ACC_W:0]   soma_s, acc_wide_s;

  // Flags a setpoint containing any non-BCD digit.
  always_comb begin
    digito_invalido_s = (bcd_3 > 4'd9) || (bcd_2 > 4'd9) ||
                        (bcd_1 > 4'd9) || (bcd_0 > 4'd9);
  end

  // Next-state logic of the load/convert/apply sequencer.
  always_comb begin
    estado_next_s = estado_r;
    case (estado_r)
      IDLE: begin
        if (carga && !digito_invalido_s) estado_next_s = CONV;
        else                             estado_next_s = IDLE;
      end
      CONV: begin
        if (idx_r == 2'd0) estado_next_s = APPLY;
        else               estado_next_s = CONV;
      end
      APPLY:   estado_next_s = IDLE;
      default: estado_next_s = IDLE;
    endcase
  end

  // Datapath and output next values: BCD conversion plus phase accumulator.
  always_comb begin
    idx_next_s        = idx_r;
    bin_next_s        = bin_r;
    inc_next_s        = inc_r;
    shadow_next_s     = shadow_r;
    ocupado_next_s    = ocupado;
    erro_next_s       = erro;
    acc_next_s        = acc_r;
    acc_wide_s        = '0;
    clk_gerado_next_s = clk_gerado;
    pulso_next_s      = pulso;
    soma_s            = {1'b0, acc_r} + (ACC_W + 1)'(inc_r);

    case (estado_r)
      IDLE: begin
        if (carga) begin
          shadow_next_s[3] = bcd_3;
          shadow_next_s[2] = bcd_2;
          shadow_next_s[1] = bcd_1;
          shadow_next_s[0] = bcd_0;
          erro_next_s      = digito_invalido_s;
          if (!digito_invalido_s) begin
            ocupado_next_s = 1'b1;
            bin_next_s     = 14'd0;
            idx_next_s     = 2'd3;
          end else begin
            ocupado_next_s = 1'b0;
          end
        end else begin
          ocupado_next_s = 1'b0;
        end
      end
      CONV: begin
        // Horner evaluation, thousands digit first.
        bin_next_s = bin_r * 14'd10 + {10'd0, shadow_r[idx_r]};
        idx_next_s = idx_r - 2'd1;
      end
      APPLY: begin
        inc_next_s     = bin_r;
        ocupado_next_s = 1'b0;
      end
      default: begin
        ocupado_next_s = 1'b0;
      end
    endcase

    if (estado_r == APPLY) begin
      acc_next_s        = '0;
      clk_gerado_next_s = 1'b0;
      pulso_next_s      = 1'b0;
    end else if (hab) begin
      if (soma_s >= MOD_VAL) begin
        acc_wide_s   = soma_s - MOD_VAL;
        pulso_next_s = 1'b1;
      end else begin
        acc_wide_s   = soma_s;
        pulso_next_s = 1'b0;
      end
      acc_next_s        = acc_wide_s[ACC_W-1:0];
      clk_gerado_next_s = (acc_wide_s >= HALF_VAL);
    end else begin
      acc_next_s        = '0;
      clk_gerado_next_s = 1'b0;
      pulso_next_s      = 1'b0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_sistema_100k or posedge reset_sistema) begin
    if (reset_sistema) begin
      estado_r   <= IDLE;
      idx_r      <= 2'd0;
      bin_r      <= 14'd0;
      inc_r      <= 14'd0;
      acc_r      <= '0;
      shadow_r   <= '{default: 4'd0};
      clk_gerado <= 1'b0;
      pulso      <= 1'b0;
      ocupado    <= 1'b0;
      erro       <= 1'b0;
    end else begin
      estado_r   <= estado_next_s;
      idx_r      <= idx_next_s;
      bin_r      <= bin_next_s;
      inc_r      <= inc_next_s;
      acc_r      <= acc_next_s;
      shadow_r   <= shadow_next_s;
      clk_gerado <= clk_gerado_next_s;
      pulso      <= pulso_next_s;
      ocupado    <= ocupado_next_s;
      erro       <= erro_next_s;
    end
  end

endmodule

// File: tb/tb_gerador_freq.sv
// Directed and randomized checks of gerador_freq against a closed-form model:
// phase after n accumulations of f Hz is (n*f) mod F_CLK.
module tb_gerador_freq;

  localparam longint F = 100000;

  logic       clk = 1'b0;
  logic       reset_sistema = 1'b1;
  logic       carga = 1'b0;
  logic       hab = 1'b0;
  logic [3:0] bcd_3 = 4'd0, bcd_2 = 4'd0, bcd_1 = 4'd0, bcd_0 = 4'd0;
  logic       clk_gerado, pulso, ocupado, erro;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int     m_busy = 0;
  int     m_val  = 0;
  longint m_inc  = 0;
  longint m_n    = 0;
  bit     m_erro = 1'b0;
  bit     exp_clk = 1'b0, exp_pulso = 1'b0;

  int pulses = 0;
  int high_cnt = 0;

  gerador_freq dut (
    .clk_sistema_100k(clk),
    .reset_sistema   (reset_sistema),
    .carga           (carga),
    .hab             (hab),
    .bcd_3           (bcd_3),
    .bcd_2           (bcd_2),
    .bcd_1           (bcd_1),
    .bcd_0           (bcd_0),
    .clk_gerado      (clk_gerado),
    .pulso           (pulso),
    .ocupado         (ocupado),
    .erro            (erro)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_bcd(input int d3, input int d2, input int d1, input int d0);
    bcd_3 = 4'(d3); bcd_2 = 4'(d2); bcd_1 = 4'(d1); bcd_0 = 4'(d0);
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare.
  task automatic step();
    bit     apply;
    longint tot;
    @(posedge clk);
    apply = (m_busy == 1);
    if (m_busy == 0) begin
      if (carga) begin
        if (bcd_3 > 9 || bcd_2 > 9 || bcd_1 > 9 || bcd_0 > 9) begin
          m_erro = 1'b1;
        end else begin
          m_erro = 1'b0;
          m_busy = 5;
          m_val  = int'(bcd_3) * 1000 + int'(bcd_2) * 100 + int'(bcd_1) * 10 + int'(bcd_0);
        end
      end
    end else begin
      m_busy--;
    end
    if (apply) begin
      m_inc = m_val; m_n = 0; exp_clk = 1'b0; exp_pulso = 1'b0;
    end else if (hab) begin
      m_n++;
      tot       = m_n * m_inc;
      exp_clk   = ((tot % F) >= F / 2);
      exp_pulso = ((tot / F) != ((tot - m_inc) / F));
    end else begin
      m_n = 0; exp_clk = 1'b0; exp_pulso = 1'b0;
    end
    #1;
    check("clk_gerado", clk_gerado, exp_clk);
    check("pulso", pulso, exp_pulso);
    check("ocupado", ocupado, m_busy != 0);
    check("erro", erro, m_erro);
    if (pulso === 1'b1) pulses++;
    if (clk_gerado === 1'b1) high_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int d3, input int d2, input int d1, input int d0);
    set_bcd(d3, d2, d1, d0);
    carga = 1'b1;
    step();
    carga = 1'b0;
    run(5);
  endtask

  initial begin
    int ocup_cnt;
    int first;
    int k;

    #12;
    check("rst_clk_gerado", clk_gerado, 0);
    check("rst_pulso", pulso, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_erro", erro, 0);
    reset_sistema = 1'b0;
    hab = 1'b1;

    // 1000 Hz: 5-cycle busy window, 100-cycle period, 50/50 duty
    set_bcd(1, 0, 0, 0);
    carga = 1'b1;
    step();
    carga = 1'b0;
    ocup_cnt = (ocupado === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ocupado === 1'b1) ocup_cnt++;
    end
    check("ocupado_len", ocup_cnt, 5);
    pulses = 0; high_cnt = 0;
    run(10000);
    check("pulses_1000hz", pulses, 100);
    check("high_1000hz", high_cnt, 5000);

    // 3 Hz: first period ends on the 33334th accumulation
    load(0, 0, 0, 3);
    pulses = 0; first = 0;
    for (int i = 1; i <= 40000; i++) begin
      step();
      if (pulso === 1'b1 && first == 0) first = i;
    end
    check("first_pulse_3hz", first, 33334);
    check("pulses_3hz", pulses, 1);

    // 9999 Hz, then an invalid load that must not disturb the output
    load(9, 9, 9, 9);
    pulses = 0;
    run(10);
    set_bcd(1, 2, 10, 4);
    carga = 1'b1;
    step();
    carga = 1'b0;
    check("bad_load_erro", erro, 1);
    check("bad_load_ocupado", ocupado, 0);
    run(9989);
    check("pulses_9999hz", pulses, 999);

    // Valid 500 Hz load clears erro
    set_bcd(0, 5, 0, 0);
    carga = 1'b1;
    step();
    carga = 1'b0;
    check("erro_cleared", erro, 0);
    run(5);
    pulses = 0;
    run(400);
    check("pulses_500hz", pulses, 2);

    // 10 Hz with an ignored request during conversion
    set_bcd(0, 0, 1, 0);
    carga = 1'b1;
    step();
    carga = 1'b0;
    run(2);
    set_bcd(0, 0, 2, 0);
    carga = 1'b1;
    step();
    carga = 1'b0;
    run(2);
    pulses = 0; first = 0;
    for (int i = 1; i <= 10100; i++) begin
      step();
      if (pulso === 1'b1 && first == 0) first = i;
    end
    check("first_pulse_10hz", first, 10000);
    check("pulses_10hz", pulses, 1);

    // Asynchronous reset in the middle of a conversion
    set_bcd(0, 5, 0, 0);
    carga = 1'b1;
    step();
    carga = 1'b0;
    run(2);
    #2;
    reset_sistema = 1'b1;
    #1;
    check("arst_ocupado", ocupado, 0);
    check("arst_clk_gerado", clk_gerado, 0);
    check("arst_pulso", pulso, 0);
    check("arst_erro", erro, 0);
    m_busy = 0; m_val = 0; m_inc = 0; m_n = 0; m_erro = 1'b0;
    exp_clk = 1'b0; exp_pulso = 1'b0;
    #2;
    reset_sistema = 1'b0;
    pulses = 0; high_cnt = 0;
    run(300);
    check("post_rst_pulses", pulses, 0);
    check("post_rst_high", high_cnt, 0);

    // hab gating at 1000 Hz: phase restarts when hab rises
    load(1, 0, 0, 0);
    run(250);
    hab = 1'b0;
    pulses = 0; high_cnt = 0;
    run(37);
    check("hab_off_pulses", pulses, 0);
    check("hab_off_high", high_cnt, 0);
    hab = 1'b1;
    k = 0;
    while (k < 200) begin
      step();
      k++;
      if (pulso === 1'b1) break;
    end
    check("hab_first_pulse", k, 100);

    // Randomized loads, occasional invalid digits and hab drops
    for (int it = 0; it < 12; it++) begin
      set_bcd($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
              $urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) bcd_1 = 4'($urandom_range(10, 15));
      carga = 1'b1;
      step();
      carga = 1'b0;
      hab = ($urandom_range(0, 3) != 0);
      run($urandom_range(50, 400));
      hab = 1'b1;
      run($urandom_range(10, 60));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
